seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Iterative restoring divider, the inverse of the main start/ready multiply/power engine.
//   Takes a wide dividend and a narrower divisor, and returns quotient and remainder, one quotient bit per clock.
//   Sits beside main. Uses the same start/ready handshake so the same sequencer or bench can drive both.
// PARAMETERS
//   NW  256  dividend / quotient width (matches main's out width)
//   DW  64   divisor / remainder width (matches main's operand width)
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   reset      in   1    asynchronous, active-low; 0 clears all state immediately
//   start      in   1    pulse; sampled only in IDLE or DONE
//   num        in   NW   dividend; captured on the accepting edge, may change afterwards
//   den        in   DW   divisor; captured on the accepting edge
//   quotient   out  NW   num / den, valid while ready=1
//   remainder  out  DW   num % den, valid while ready=1
//   ready      out  1    result valid; held until the next accepted start
//   busy       out  1    1 while a division is running
//   div_zero   out  1    den was 0 for the current result; valid with ready
// BEHAVIOUR
//   Reset (reset=0, async):
//     state=IDLE; quotient=0, remainder=0, ready=0, busy=0, div_zero=0; internal regs and counter cleared.
//   States: IDLE, RUN, DONE.
//     IDLE/DONE & start=1, den!=0 -> RUN.
//       Accepting edge: load q_sh=num, rem=0 (DW+1 bits), cnt=NW; ready<=0, busy<=1, div_zero<=0.
//     IDLE/DONE & start=1, den==0 -> DONE.
//       quotient<=all ones, remainder<=num[DW-1:0], div_zero<=1, ready<=1, busy stays 0. Latency 1 edge.
//     RUN, each edge:
//       t = {rem[DW-1:0], q_sh[NW-1]}
//       if t >= {1'b0,den}: rem <= t - den, bit=1; else rem <= t, bit=0
//       q_sh <= {q_sh[NW-2:0], bit}; cnt <= cnt-1
//     RUN & cnt==1 (last step) -> DONE.
//       quotient/remainder take the final values on that edge; ready<=1, busy<=0.
//   Latency: ready rises NW+1 edges after the accepting edge (257 for defaults). Fixed, data-independent.
//   Width rules:
//     Comparison and subtraction are unsigned, DW+1 bits wide. Remainder always < den, so it fits DW bits.
//     cnt is $clog2(NW+1) bits.
//   Boundary conditions:
//     start while RUN: ignored; current operation and outputs are unaffected.
//     start held high continuously: a new operation is accepted on each edge where state is IDLE/DONE, i.e.
//       back-to-back divisions; ready pulses for one cycle between them.
//     num < den: quotient=0, remainder=num. num==den: quotient=1, remainder=0. den==1: quotient=num, remainder=0.
//     reset asserted mid-RUN: abort immediately to reset values. The first start after release is accepted normally.
//     start on the first edge after reset release: accepted (no extra idle cycle required).
//     quotient/remainder registers change only on the final RUN edge or the div-zero edge. They never show
//       partial results.
// STRUCTURE
//   div_pkg:
//     localparams NW_DEF=256, DW_DEF=64.
//     State encoding typedef/localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//     Function clog2 for the counter width.
//   Sub-module div_step (combinational, parameter DW):
//     in rem, in_bit, den -> out rem_next, q_bit.
//     Keeps the datapath separate from the FSM/counter in seq_divider.
//   seq_divider holds the FSM, counter, shift registers and output registers. No memories, no multicycle paths.
// TESTING
//   1. num=7, den=3, 1-cycle start
//        -> busy=1 next cycle; ready=1 exactly 257 edges after the accepting edge; quotient=2, remainder=1,
//           div_zero=0.
//   2. num=2^64 (main's 2^64 result), den=2
//        -> quotient=2^63, remainder=0.
//      num=2^256-1, den=2^64-1
//        -> quotient=2^192+2^128+2^64+1, remainder=0.
//   3. num=5, den=9 -> quotient=0, remainder=5.
//      num=den=64'hFFFF_FFFF_FFFF_FFFF -> quotient=1, remainder=0.
//   4. den=0, num=0x1234 -> ready=1 after 1 edge, div_zero=1, quotient=all ones, remainder=0x1234, busy never 1.
//   5. num=100, den=7, start; pulse start again at edge 50 with num=9, den=3
//        -> second start ignored; result quotient=14, remainder=2.
//      Then start num=9, den=3 -> quotient=3, remainder=0.
//   6. Start num=1000, den=10, drive reset=0 at edge 100 between clock edges
//        -> all outputs 0 immediately (async).
//      Release, start num=1000, den=10 -> quotient=100, remainder=0 at 257 edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default widths, FSM state
// encoding and a constant function for sizing the step counter.
package div_pkg;

  localparam int NW_DEF = 256;
  localparam int DW_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, and subtract the divisor when it fits.
module div_step #(
  parameter int DW = 64
) (
  input  logic [DW-1:0] rem,
  input  logic          in_bit,
  input  logic [DW-1:0] den,
  output logic [DW-1:0] rem_next,
  output logic          q_bit
);

  logic [DW:0] t;

  // The partial remainder is always below den, so t fits DW+1 bits and the
  // restored result fits back into DW bits; the low-DW subtraction is exact
  // whenever t >= den.
  always_comb begin
    t        = {rem, in_bit};
    q_bit    = (t >= {1'b0, den});
    rem_next = q_bit ? (t[DW-1:0] - den) : t[DW-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with a start/ready handshake.
//
// Handshake: start is sampled only in IDLE or DONE. The edge that samples
// start=1 is the accepting edge; num/den are captured there and may change
// afterwards. ready stays high with a valid quotient/remainder/div_zero until
// the next accepted start; busy is high while the NW stepping edges run.
// A zero divisor completes on the accepting edge itself with div_zero=1.
module seq_divider
  import div_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          ready,
  output logic          busy,
  output logic          div_zero
);

  localparam int CW = clog2(NW + 1);

  state_t        state;
  state_t        state_next;
  logic [NW-1:0] q_sh;
  logic [DW-1:0] rem;
  logic [DW-1:0] den_r;
  logic [CW-1:0] cnt;

  logic          accept_run;
  logic          accept_zero;
  logic          do_step;
  logic          last_step;

  logic [DW-1:0] rem_next;
  logic          q_bit;

  div_step #(.DW(DW)) u_step (
    .rem      (rem),
    .in_bit   (q_sh[NW-1]),
    .den      (den_r),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept_zero)     state_next = DONE;
        else if (accept_run) state_next = RUN;
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM control outputs driving the datapath.
  always_comb begin
    accept_run  = 1'b0;
    accept_zero = 1'b0;
    do_step     = 1'b0;
    last_step   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (den == '0) accept_zero = 1'b1;
          else           accept_run  = 1'b1;
        end
      end
      RUN: begin
        do_step   = 1'b1;
        last_step = (cnt == CW'(1));
      end
      default: ;
    endcase
  end

  // Datapath: working registers step every RUN edge; the visible result
  // registers load only on the final step or on a zero-divisor accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_sh      <= '0;
      rem       <= '0;
      den_r     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else if (accept_run) begin
      q_sh     <= num;
      rem      <= '0;
      den_r    <= den;
      cnt      <= CW'(NW);
      ready    <= 1'b0;
      busy     <= 1'b1;
      div_zero <= 1'b0;
    end else if (accept_zero) begin
      quotient  <= '1;
      remainder <= num[DW-1:0];
      div_zero  <= 1'b1;
      ready     <= 1'b1;
      busy      <= 1'b0;
    end else if (do_step) begin
      q_sh <= {q_sh[NW-2:0], q_bit};
      rem  <= rem_next;
      cnt  <= cnt - CW'(1);
      if (last_step) begin
        quotient  <= {q_sh[NW-2:0], q_bit};
        remainder <= rem_next;
        ready     <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: fixed vectors, handshake corner sequences and random
// operands checked against a plain-arithmetic division model.
module tb_seq_divider;

  localparam int NW      = 256;
  localparam int DW      = 64;
  localparam int LAT_MAX = NW + 20;
  localparam int EW      = NW + DW + 1;

  typedef struct {
    string         name;
    logic [NW-1:0] num;
    logic [DW-1:0] den;
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [NW-1:0] num;
  logic [DW-1:0] den;
  logic [NW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          ready;
  logic          busy;
  logic          div_zero;

  int checks;
  int failures;

  logic [NW-1:0] held_q;
  logic [DW-1:0] held_r;
  logic [EW-1:0] exp_q[$];

  seq_divider #(.NW(NW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num       (num),
    .den       (den),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (ready),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: quotient and remainder straight from wide arithmetic.
  function automatic logic [EW-1:0] model(input logic [NW-1:0] n, input logic [DW-1:0] d);
    logic [NW-1:0] dd;
    logic [NW-1:0] qq;
    logic [NW-1:0] rr;
    if (d == '0) return {{NW{1'b1}}, n[DW-1:0], 1'b1};
    dd = {{(NW-DW){1'b0}}, d};
    qq = n / dd;
    rr = n % dd;
    return {qq, rr[DW-1:0], 1'b0};
  endfunction

  // Present operands with start high through one edge (called just after an edge).
  task automatic launch(input logic [NW-1:0] n, input logic [DW-1:0] d);
    num   = n;
    den   = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for ready, counting edges; lat counts the accepting edge as edge 1.
  task automatic wait_ready(inout int lat, output logic busy_first,
                            output logic saw_busy, output logic stable);
    busy_first = busy;
    saw_busy   = busy;
    stable     = 1'b1;
    while (!ready && lat < LAT_MAX) begin
      if (quotient !== held_q || remainder !== held_r) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
      saw_busy = saw_busy | busy;
    end
  endtask

  task automatic check_result(input string name, input int lat, input logic busy_first,
                              input logic saw_busy, input logic stable,
                              input logic [NW-1:0] eq, input logic [DW-1:0] er, input logic edz);
    check($sformatf("%s.ready", name), NW'(ready), NW'(1));
    check($sformatf("%s.quotient", name), quotient, eq);
    check($sformatf("%s.remainder", name), NW'(remainder), NW'(er));
    check($sformatf("%s.div_zero", name), NW'(div_zero), NW'(edz));
    check($sformatf("%s.latency", name), NW'(lat), edz ? NW'(1) : NW'(NW + 1));
    check($sformatf("%s.no_partial", name), NW'(stable), NW'(1));
    if (edz) check($sformatf("%s.busy_never", name), NW'(saw_busy), NW'(0));
    else     check($sformatf("%s.busy_next", name), NW'(busy_first), NW'(1));
    held_q = eq;
    held_r = er;
  endtask

  task automatic check_idle_zero(input string name);
    check($sformatf("%s.quotient", name), quotient, '0);
    check($sformatf("%s.remainder", name), NW'(remainder), '0);
    check($sformatf("%s.ready", name), NW'(ready), '0);
    check($sformatf("%s.busy", name), NW'(busy), '0);
    check($sformatf("%s.div_zero", name), NW'(div_zero), '0);
  endtask

  vec_t vecs[10];

  initial begin
    int            lat;
    logic          bf, sb, st;
    logic [NW-1:0] rn;
    logic [DW-1:0] rd;
    logic [EW-1:0] e;

    checks   = 0;
    failures = 0;

    vecs[0] = '{"v_7_3",      NW'(7), DW'(3), NW'(2), DW'(1), 1'b0};
    vecs[1] = '{"v_2p64_2",   NW'(1) << 64, DW'(2), NW'(1) << 63, DW'(0), 1'b0};
    vecs[2] = '{"v_max_max64", {NW{1'b1}}, {DW{1'b1}},
                {64'd1, 64'd1, 64'd1, 64'd1}, DW'(0), 1'b0};
    vecs[3] = '{"v_5_9",      NW'(5), DW'(9), NW'(0), DW'(5), 1'b0};
    vecs[4] = '{"v_eq",       NW'(64'hFFFF_FFFF_FFFF_FFFF), 64'hFFFF_FFFF_FFFF_FFFF,
                NW'(1), DW'(0), 1'b0};
    vecs[5] = '{"v_div0",     NW'(16'h1234), DW'(0), {NW{1'b1}}, DW'(16'h1234), 1'b0};
    vecs[5].dz = 1'b1;
    vecs[6] = '{"v_den1",     {64'hDEAD_BEEF_0123_4567, 64'h0, 64'h89AB_CDEF_FEDC_BA98, 64'h5},
                DW'(1), {64'hDEAD_BEEF_0123_4567, 64'h0, 64'h89AB_CDEF_FEDC_BA98, 64'h5},
                DW'(0), 1'b0};
    vecs[7] = '{"v_100_7",    NW'(100), DW'(7), NW'(14), DW'(2), 1'b0};
    vecs[8] = '{"v_0_5",      NW'(0), DW'(5), NW'(0), DW'(0), 1'b0};
    vecs[9] = '{"v_2p128p3_2p64", (NW'(1) << 128) + NW'(3), DW'(1) << 63,
                NW'(1) << 65, DW'(3), 1'b0};

    // Reset.
    reset = 1'b0;
    start = 1'b0;
    num   = '0;
    den   = '0;
    held_q = '0;
    held_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b1;

    // Fixed vectors; the first one is accepted on the first edge after release.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].num, vecs[i].den);
      lat = 1;
      wait_ready(lat, bf, sb, st);
      check_result(vecs[i].name, lat, bf, sb, st, vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // start during RUN is ignored.
    launch(NW'(100), DW'(7));
    lat = 1;
    repeat (48) begin
      @(posedge clk); #1;
      lat++;
    end
    launch(NW'(9), DW'(3));
    lat++;
    wait_ready(lat, bf, sb, st);
    check_result("ignore_start", lat, 1'b1, sb, st, NW'(14), DW'(2), 1'b0);
    launch(NW'(9), DW'(3));
    lat = 1;
    wait_ready(lat, bf, sb, st);
    check_result("after_ignore", lat, bf, sb, st, NW'(3), DW'(0), 1'b0);

    // start held high: back-to-back, ready high for exactly one sample.
    num   = NW'(12345);
    den   = DW'(100);
    start = 1'b1;
    @(posedge clk); #1;
    num = NW'(77);
    den = DW'(8);
    lat = 1;
    wait_ready(lat, bf, sb, st);
    check_result("b2b_first", lat, bf, sb, st, NW'(123), DW'(45), 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b.ready_pulse", NW'(ready), NW'(0));
    check("b2b.busy_again", NW'(busy), NW'(1));
    lat = 1;
    wait_ready(lat, bf, sb, st);
    check_result("b2b_second", lat, bf, sb, st, NW'(9), DW'(5), 1'b0);

    // Asynchronous reset mid-run, then restart on the first edge after release.
    launch(NW'(1000), DW'(10));
    repeat (99) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_idle_zero("async_reset");
    held_q = '0;
    held_r = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    launch(NW'(1000), DW'(10));
    lat = 1;
    wait_ready(lat, bf, sb, st);
    check_result("after_reset", lat, bf, sb, st, NW'(100), DW'(0), 1'b0);

    // Random operands against the arithmetic model.
    for (int k = 0; k < 16; k++) begin
      for (int w = 0; w < NW / 32; w++) rn[w*32 +: 32] = $urandom;
      rn = rn >> $urandom_range(0, NW - 1);
      case ($urandom_range(0, 4))
        0:       rd = '0;
        1:       rd = DW'($urandom_range(1, 255));
        2:       rd = {32'h0, $urandom} | DW'(1);
        3:       rd = {$urandom, $urandom} | (DW'(1) << 63);
        default: rd = DW'(1);
      endcase
      exp_q.push_back(model(rn, rd));
      launch(rn, rd);
      lat = 1;
      wait_ready(lat, bf, sb, st);
      e = exp_q.pop_front();
      check_result($sformatf("rand%0d", k), lat, bf, sb, st,
                   e[EW-1 -: NW], e[DW:1], e[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
